bin2bcd_display: RTL
====================

# bin2bcd_display

Sequential binary-to-BCD converter that sits between the CPU's 32-bit `io2_out` display port and the eight `hexdriver` instances. It turns the CPU's binary output into eight decimal digits so the seven-segment displays read in decimal rather than hex. Conversion is iterative double-dabble (shift-add-3), one bit per clock. Results are double-buffered, so the displays never show a partially converted value.

## Interface
- `BLANK_LZ`, default 1: when 1, leading-zero digits are flagged for blanking; when 0, `blank_n` is all ones.
- `clk`  in  1  system clock (CLOCK_50 domain); all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset (driven from KEY[0]).
- `bin_in`  in  32  unsigned binary value from CPU `io2_out`.
- `bcd_out`  out  32  eight packed BCD digits; `[3:0]` is units and `[31:28]` is 10^7. Feeds hexdriver 0..7.
- `blank_n`  out  8  per-digit enable; 1 = display the digit, 0 = blank it.
- `overflow`  out  1  last converted value is greater than 99,999,999.
- `busy`  out  1  a conversion is in progress.
- `done`  out  1  one-cycle pulse when the outputs update.

## Operation
- Internal registers:
  - `last_val[31:0]`: value most recently captured.
  - `shreg[31:0]`: binary shift register.
  - `bcd_acc[39:0]`: 10-digit accumulator.
  - `cnt[4:0]`.
  - `state` ∈ {IDLE, SHIFT}.
- **IDLE**: each cycle, compare `bin_in` with `last_val`.
  - On mismatch: `last_val <= bin_in`, `shreg <= bin_in`, `bcd_acc <= 0`, `cnt <= 0`, go to SHIFT.
  - On match: stay in IDLE.
- **SHIFT**: each cycle, first add 3 to every accumulator digit that is ≥5 (all 10 digits in parallel). Then shift `{bcd_acc, shreg}` left by one and increment `cnt`.
- When `cnt == 31` (the 32nd iteration), the post-shift accumulator is written directly to the output registers and state returns to IDLE:
  - `bcd_out <= acc[31:0]`
  - `overflow <= |acc[39:32]`
  - `blank_n` computed as below
  - `done <= 1` for one cycle
- Blanking rule:
  - `blank_n[0]` is always 1.
  - `blank_n[i]` for i = 1..7 is 1 if any digit j ≥ i is nonzero, or if `overflow` is set.
  - If `BLANK_LZ == 0`, `blank_n` is 8'hFF.
- On overflow, `bcd_out` holds the low 8 decimal digits of the true value.
- `bin_in` changes while in SHIFT are ignored. After `done`, IDLE compares again and restarts if `bin_in != last_val`. Only the final stable value is guaranteed to be displayed; intermediate values may be skipped.
- Outputs change only on the `done` cycle and hold between conversions.
- Width rules:
  - Add-3 is a 4-bit add with no carry out of the digit; a digit ≥5 never exceeds 9 before the add.
  - The 40-bit accumulator covers the maximum value 4,294,967,295.

## Timing
- Reset (asynchronous, immediate; aborts any conversion and returns to IDLE):
  - `bcd_out = 0`, `blank_n = 8'h01`, `overflow = 0`, `busy = 0`, `done = 0`
  - `last_val = 0`, `cnt = 0`
- Because `last_val` resets to 0, `bin_in == 0` after reset triggers no conversion.
- Latency, with `bin_in` changing before edge E0 while in IDLE:
  - E0: capture; `busy = 1` from E0.
  - E1..E32: the 32 shift iterations.
  - E32: outputs update, `done = 1`, `busy = 0`. `done` is high only between E32 and E33.
- Earliest next capture is E33. Back-to-back conversions therefore have a period of 33 cycles.
- `busy` and `done` are never high in the same cycle.
- Minimum `done` spacing is 33 cycles.

## Test plan
- **Reset, `bin_in = 0`**:
  - Required: `bcd_out = 0`, `blank_n = 8'h01`, `overflow = 0`.
  - Required: `busy` stays 0 for 100 cycles; no `done`.
- **`bin_in = 12345` (the simulated switch value)**:
  - Required: `busy` rises at the capture edge; `done` follows exactly 32 edges later.
  - Required: `bcd_out = 32'h0001_2345`, `blank_n = 8'h1F`, `overflow = 0`.
- **Range boundaries**:
  - 99,999,999 → `32'h9999_9999`, `blank_n = 8'hFF`, `overflow = 0`.
  - 100,000,000 → `32'h0000_0000`, `overflow = 1`, `blank_n = 8'hFF`.
  - 32'hFFFF_FFFF → `32'h9496_7295`, `overflow = 1`.
- **Mid-conversion change**: `bin_in = 12345`, then changed to 678 at SHIFT cycle 10.
  - Required: first `done` shows `32'h0001_2345`.
  - Required: a new capture at the next edge, then a second `done` 33 cycles after the first showing `32'h0000_0678` with `blank_n = 8'h07`.
  - Required: `bcd_out` takes no other values.
- **Reset mid-conversion**: assert `rst_n` low at SHIFT cycle 15 of a conversion of 4321.
  - Required: outputs immediately return to reset values and no `done` is produced.
  - Required: after release, 4321 is reconverted to `32'h0000_4321` in 33 edges.
- **`BLANK_LZ = 0`, `bin_in = 7`**:
  - Required: `bcd_out = 32'h0000_0007`, `blank_n = 8'hFF`.

Source files
------------

// File: rtl/bin2bcd_display.sv
// Iterative double-dabble converter from a 32-bit binary value to eight BCD digits.
// Results are double-buffered: the display outputs only change on the done cycle.
module bin2bcd_display #(
  parameter logic BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bin_in,
  output logic [31:0] bcd_out,
  output logic [7:0]  blank_n,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [31:0] last_val_q, last_val_d;
  logic [31:0] shreg_q, shreg_d;
  logic [39:0] bcd_acc_q, bcd_acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] bcd_out_q, bcd_out_d;
  logic [7:0]  blank_n_q, blank_n_d;
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;

  logic [39:0] adj;
  logic [71:0] shifted;
  logic [39:0] acc_next;
  logic        ovf_next;
  logic [7:0]  blank_next;
  logic        seen_nonzero;

  // Add-3 correction on every digit, then shift the combined {acc, shreg} left by one.
  always_comb begin
    adj = bcd_acc_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_acc_q[4*i +: 4] + 4'd3;
      end
    end
    shifted  = {adj, shreg_q} << 1;
    acc_next = shifted[71:32];
    ovf_next = |acc_next[39:32];
  end

  // A digit is shown if it or any more significant digit is nonzero.
  always_comb begin
    blank_next   = 8'h01;
    seen_nonzero = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      seen_nonzero  = seen_nonzero | (acc_next[4*i +: 4] != 4'd0);
      blank_next[i] = seen_nonzero | ovf_next;
    end
    if (!BLANK_LZ) begin
      blank_next = 8'hFF;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    shreg_d    = shreg_q;
    bcd_acc_d  = bcd_acc_q;
    cnt_d      = cnt_q;
    bcd_out_d  = bcd_out_q;
    blank_n_d  = blank_n_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bin_in != last_val_q) begin
          last_val_d = bin_in;
          shreg_d    = bin_in;
          bcd_acc_d  = 40'd0;
          cnt_d      = 5'd0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_acc_d = acc_next;
        shreg_d   = shifted[31:0];
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          bcd_out_d  = acc_next[31:0];
          overflow_d = ovf_next;
          blank_n_d  = blank_next;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_val_q <= 32'd0;
      shreg_q    <= 32'd0;
      bcd_acc_q  <= 40'd0;
      cnt_q      <= 5'd0;
      bcd_out_q  <= 32'd0;
      blank_n_q  <= 8'h01;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      shreg_q    <= shreg_d;
      bcd_acc_q  <= bcd_acc_d;
      cnt_q      <= cnt_d;
      bcd_out_q  <= bcd_out_d;
      blank_n_q  <= blank_n_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bcd_out  = bcd_out_q;
  assign blank_n  = blank_n_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == SHIFT);
  assign done     = done_q;

endmodule
